gpio_in_capture: RTL and testbench
==================================

# gpio_in_capture

Receive-side GPIO input block. It is the DUT end of the GPIO pin bus that the GPIO UVC driver stimulates. It synchronizes each asynchronous `gpio_pin` bit into the `clk` domain and optionally debounces it. It then detects rising and falling edges, latches them into sticky status bits and raises a masked, registered interrupt.

## Interface
Parameters:
- `WIDTH`, 8: number of GPIO pins.
- `SYNC_STAGES`, 2: synchronizer flops per pin; legal values are 2 or more.
- `DBNC_W`, 8: width of the debounce limit and of each per-pin counter.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `gpio_pin`, input, WIDTH: asynchronous pin levels.
- `dbnc_limit`, input, DBNC_W: consecutive cycles of disagreement required before the stable value updates. A value of 0 behaves as 1.
- `rise_en`, input, WIDTH: per-pin enable for rising-edge capture.
- `fall_en`, input, WIDTH: per-pin enable for falling-edge capture.
- `irq_mask`, input, WIDTH: per-pin interrupt enable.
- `status_clr`, input, WIDTH: per-pin clear pulse for `edge_status`, one cycle wide.
- `gpio_value`, output, WIDTH: debounced stable level.
- `edge_status`, output, WIDTH: sticky edge-captured flags.
- `irq`, output, 1: registered interrupt.

## Operation
- **Reset.** All synchronizer flops, `gpio_value`, debounce counters, `edge_status` and `irq` reset to 0.
- **Synchronizer.** Each pin passes through a chain of SYNC_STAGES flops. `sync[i]` is the last stage.
- **Debounce, per pin.**
  - If `sync[i] == gpio_value[i]`, the counter clears to 0.
  - Otherwise, if `cnt >= max(dbnc_limit,1) - 1`, then `gpio_value[i] <= sync[i]` and the counter clears to 0.
  - Otherwise the counter increments.
  - Because the comparison is `>=`, lowering `dbnc_limit` mid-count takes effect immediately. The counter never wraps.
- **Glitch rejection.** A pulse shorter than the limit never reaches `gpio_value`. Its counter returns to 0 as soon as `sync` agrees with `gpio_value` again.
- **Edge detect.** A rise on pin i is `gpio_value[i]` going 0→1 on a clock edge; a fall is 1→0. On the next edge, `edge_status[i]` is set if `(rise & rise_en[i]) | (fall & fall_en[i])`.
- **Status.** Set-dominant sticky bit. `status_clr[i]` clears it only when no set event occurs in the same cycle. Clearing an already-clear bit has no effect.
- **Interrupt.** `irq <= |(edge_status & irq_mask)`. Changing the mask updates `irq` one cycle later and does not alter `edge_status`.
- **Edge captured at reset release.** A pin held high through reset appears as a 0→1 transition after release. It is captured if `rise_en` is set, and software clears it.

## Timing
- Take a pin change sampled at edge k, with `S = SYNC_STAGES` and `L = max(dbnc_limit,1)`.
  - `gpio_value` updates at edge k+S+L-1.
  - `edge_status` sets at edge k+S+L.
  - `irq` asserts at edge k+S+L+1.
- With S=2 and L=1, the pin-to-irq latency is 4 cycles.
- `status_clr` at edge n drops `edge_status` at n and `irq` at n+1, unless a new event sets the bit.
- When `rst_n` is asserted mid-debounce, all state clears immediately and asynchronously. No edge is reported for the interrupted change.

## Configuration
- `GPIO_IN_DEBOUNCE_EN` defined: the per-pin counters and `dbnc_limit` behave as described above.
- Undefined:
  - No counters are built.
  - `gpio_value <= sync` every cycle, i.e. L fixed at 1.
  - `dbnc_limit` is ignored and left unconnected.
  - Pin-to-`gpio_value` latency is S cycles.

## Structure
- `gpio_in_pkg` holds the `dbnc_cnt_t` typedef (`logic [DBNC_W-1:0]`) and the `GPIO_IN_MIN_SYNC = 2` constant. An elaboration check rejects SYNC_STAGES below this constant.
- Sub-module `gpio_in_bit` holds one pin's synchronizer, debounce counter, stable flop, edge detect and sticky status. It is instantiated WIDTH times in a generate loop.
- The top level contains only the irq reduction flop.

## Test plan
- **Reset.** With `rst_n`=0 and any `gpio_pin` → all outputs 0. Release with `gpio_pin=8'h00` → no status is set.
- **Clean rise, no debounce.** `dbnc_limit`=1, `rise_en`=FF, `irq_mask`=FF; drive `gpio_pin[3]` 0→1 at edge k → `gpio_value[3]`=1 at k+2, `edge_status`=8'h08 at k+3, `irq`=1 at k+4.
- **Glitch rejection.** `dbnc_limit`=5; a 3-cycle high pulse on pin 0 → `gpio_value` and `edge_status` stay 0. Then hold pin 0 high for 5+ cycles → `gpio_value[0]`=1 at k+6.
- **Fall enable only.** `rise_en`=0, `fall_en`=8'h01; pin 0 goes 1→0 after settling high → `edge_status`=8'h01. The preceding rise leaves the status at 0.
- **Set/clear collision.** `status_clr[2]` pulsed in the same cycle a rise on pin 2 sets status → `edge_status[2]` remains 1. A later lone clear → 0, and `irq` drops one cycle later.
- **Mask and mid-operation reset.** `edge_status`=8'h10 with `irq_mask`=0 → `irq`=0; set the mask → `irq`=1 the next cycle. Assert `rst_n` low mid-debounce → everything is 0 immediately.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: shared types and constants for the GPIO input capture block.
//   GPIO_IN_MIN_SYNC : minimum legal synchronizer depth.
//   GPIO_IN_DBNC_W   : default debounce counter / limit width.
//   dbnc_cnt_t       : debounce counter type at the default width.
package gpio_in_pkg;

    localparam int unsigned GPIO_IN_MIN_SYNC = 2;
    localparam int unsigned GPIO_IN_DBNC_W   = 8;

    typedef logic [GPIO_IN_DBNC_W-1:0] dbnc_cnt_t;

endpackage : gpio_in_pkg

// File: rtl/gpio_in_bit.sv
// gpio_in_bit: one GPIO pin's receive path.
// The pin is synchronized, optionally debounced into a stable level, then
// edge-detected into a set-dominant sticky status bit.
// Optional feature macro: GPIO_IN_DEBOUNCE_EN (per-pin debounce counter).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pin         : asynchronous pin level
//   dbnc_limit  : debounce limit, 0 treated as 1 (only with GPIO_IN_DEBOUNCE_EN)
//   rise_en     : capture rising edges
//   fall_en     : capture falling edges
//   status_clr  : one-cycle clear of the sticky status
//   value       : debounced stable level
//   status      : sticky edge-captured flag
module gpio_in_bit
    import gpio_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = GPIO_IN_MIN_SYNC,
    parameter int unsigned DBNC_W      = $bits(dbnc_cnt_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin,
`ifdef GPIO_IN_DEBOUNCE_EN
    input  logic [DBNC_W-1:0] dbnc_limit,
`endif
    input  logic              rise_en,
    input  logic              fall_en,
    input  logic              status_clr,
    output logic              value,
    output logic              status
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   value_d;
    logic                   rise;
    logic                   fall;
    logic                   set_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [DBNC_W-1:0] cnt;
    logic [DBNC_W-1:0] lim_m1;

    // A limit of 0 behaves as 1, so the threshold saturates at 0.
    always_comb begin
        lim_m1 = '0;
        if (dbnc_limit != '0) begin
            lim_m1 = dbnc_limit - DBNC_W'(1);
        end
    end

    // Counter only increments while below lim_m1, so it can never wrap;
    // the >= compare lets a lowered limit take effect on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            value <= 1'b0;
        end else if (sync_lvl == value) begin
            cnt <= '0;
        end else if (cnt >= lim_m1) begin
            value <= sync_lvl;
            cnt   <= '0;
        end else begin
            cnt <= cnt + DBNC_W'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 1'b0;
        end else begin
            value <= sync_lvl;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_d <= 1'b0;
        end else begin
            value_d <= value;
        end
    end

    assign rise    = value & ~value_d;
    assign fall    = ~value & value_d;
    assign set_evt = (rise & rise_en) | (fall & fall_en);

    // Set wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 1'b0;
        end else begin
            status <= set_evt | (status & ~status_clr);
        end
    end

endmodule : gpio_in_bit

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: receive-side GPIO input block.
// Synchronizes and (optionally) debounces each pin, captures enabled edges
// into sticky status bits and raises a masked, registered interrupt.
// Optional feature macro: GPIO_IN_DEBOUNCE_EN (enables dbnc_limit and the
// per-pin counters; otherwise gpio_value follows the synchronizer directly).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   gpio_pin     : asynchronous pin levels
//   dbnc_limit   : debounce limit in cycles (0 behaves as 1)
//   rise_en      : per-pin rising-edge capture enable
//   fall_en      : per-pin falling-edge capture enable
//   irq_mask     : per-pin interrupt enable
//   status_clr   : per-pin one-cycle status clear
//   gpio_value   : debounced stable levels
//   edge_status  : sticky edge flags
//   irq          : registered interrupt
module gpio_in_capture
    import gpio_in_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DBNC_W      = $bits(dbnc_cnt_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  gpio_pin,
    input  logic [DBNC_W-1:0] dbnc_limit,
    input  logic [WIDTH-1:0]  rise_en,
    input  logic [WIDTH-1:0]  fall_en,
    input  logic [WIDTH-1:0]  irq_mask,
    input  logic [WIDTH-1:0]  status_clr,
    output logic [WIDTH-1:0]  gpio_value,
    output logic [WIDTH-1:0]  edge_status,
    output logic              irq
);

    if (SYNC_STAGES < GPIO_IN_MIN_SYNC) begin : g_bad_sync
        $error("gpio_in_capture: SYNC_STAGES must be at least %0d", GPIO_IN_MIN_SYNC);
    end

`ifndef GPIO_IN_DEBOUNCE_EN
    logic unused_dbnc;
    assign unused_dbnc = ^dbnc_limit;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_in_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_W      (DBNC_W)
        ) u_bit (
            .clk        (clk),
            .rst_n      (rst_n),
            .pin        (gpio_pin[i]),
`ifdef GPIO_IN_DEBOUNCE_EN
            .dbnc_limit (dbnc_limit),
`endif
            .rise_en    (rise_en[i]),
            .fall_en    (fall_en[i]),
            .status_clr (status_clr[i]),
            .value      (gpio_value[i]),
            .status     (edge_status[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_status & irq_mask);
        end
    end

endmodule : gpio_in_capture

// File: tb/tb_gpio_in_capture.sv
// tb_gpio_in_capture: directed self-checking bench for gpio_in_capture.
// Honours GPIO_IN_DEBOUNCE_EN so the same bench covers both builds.
module tb_gpio_in_capture;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int L_GLITCH = 5;
`else
    localparam int L_GLITCH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gpio_pin;
    logic [7:0] dbnc_limit;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] irq_mask;
    logic [7:0] status_clr;
    logic [7:0] gpio_value;
    logic [7:0] edge_status;
    logic       irq;

    int errors = 0;
    int checks = 0;

    gpio_in_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DBNC_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gpio_pin    (gpio_pin),
        .dbnc_limit  (dbnc_limit),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .irq_mask    (irq_mask),
        .status_clr  (status_clr),
        .gpio_value  (gpio_value),
        .edge_status (edge_status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        gpio_pin   = 8'hA5;
        dbnc_limit = 8'd1;
        rise_en    = 8'hFF;
        fall_en    = 8'hFF;
        irq_mask   = 8'hFF;
        status_clr = 8'h00;
        step(3);
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL reset_value: got %h want 00", gpio_value); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", edge_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        gpio_pin = 8'h00;
        rst_n    = 1'b1;
        step(6);
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL release_status: got %h want 00", edge_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL release_irq: got %b want 0", irq); end
    endtask

    task automatic test_clean_rise;
        fall_en     = 8'h00;
        gpio_pin[3] = 1'b1;          // sampled at edge k
        step(2);                     // after k+1
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL rise_value_early: got %h want 00", gpio_value); end
        step(1);                     // after k+2
        checks++; if (gpio_value !== 8'h08) begin errors++; $display("FAIL rise_value: got %h want 08", gpio_value); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL rise_status_early: got %h want 00", edge_status); end
        step(1);                     // after k+3
        checks++; if (edge_status !== 8'h08) begin errors++; $display("FAIL rise_status: got %h want 08", edge_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b want 0", irq); end
        step(1);                     // after k+4
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq); end
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL clr_status: got %h want 00", edge_status); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq_hold: got %b want 1", irq); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq_drop: got %b want 0", irq); end
        gpio_pin = 8'h00;            // fall not enabled, nothing captured
        step(6);
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL fall_disabled: got %h want 00", edge_status); end
    endtask

    task automatic test_glitch;
        dbnc_limit  = 8'd5;
        gpio_pin[0] = 1'b1;
        step(3);
        gpio_pin[0] = 1'b0;
        step(8);
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL glitch_value: got %h want 00", gpio_value); end
`ifdef GPIO_IN_DEBOUNCE_EN
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL glitch_status: got %h want 00", edge_status); end
`else
        checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL glitch_status: got %h want 01", edge_status); end
`endif
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        step(2);
        gpio_pin[0] = 1'b1;          // held: sampled at edge k
        step(L_GLITCH + 1);          // after k+L
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL hold_value_early: got %h want 00", gpio_value); end
        step(1);                     // after k+L+1
        checks++; if (gpio_value !== 8'h01) begin errors++; $display("FAIL hold_value: got %h want 01", gpio_value); end
        step(1);
        checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL hold_status: got %h want 01", edge_status); end
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        step(2);
    endtask

    task automatic test_fall_only;
        rise_en    = 8'h00;
        fall_en    = 8'h00;
        dbnc_limit = 8'd0;           // behaves as 1
        gpio_pin   = 8'h00;
        step(8);
        fall_en     = 8'h01;
        gpio_pin[0] = 1'b1;
        step(6);
        checks++; if (gpio_value !== 8'h01) begin errors++; $display("FAIL fall_settle_value: got %h want 01", gpio_value); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL fall_rise_ignored: got %h want 00", edge_status); end
        gpio_pin[0] = 1'b0;          // sampled at edge k
        step(3);                     // after k+2
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL fall_value: got %h want 00", gpio_value); end
        step(1);                     // after k+3
        checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL fall_status: got %h want 01", edge_status); end
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        step(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_irq_cleared: got %b want 0", irq); end
    endtask

    task automatic test_collision;
        fall_en     = 8'h00;
        rise_en     = 8'h04;
        gpio_pin[2] = 1'b1;          // sampled at edge k
        step(3);                     // after k+2
        status_clr = 8'h04;          // coincides with the set at k+3
        step(1);
        status_clr = 8'h00;
        checks++; if (edge_status !== 8'h04) begin errors++; $display("FAIL coll_status: got %h want 04", edge_status); end
        step(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq: got %b want 1", irq); end
        status_clr = 8'h04;
        step(1);
        status_clr = 8'h00;
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL lone_clr_status: got %h want 00", edge_status); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lone_clr_irq_hold: got %b want 1", irq); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lone_clr_irq_drop: got %b want 0", irq); end
        status_clr = 8'h04;          // already clear: no effect
        step(1);
        status_clr = 8'h00;
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL idle_clr: got %h want 00", edge_status); end
    endtask

    task automatic test_mask_reset;
        irq_mask    = 8'h00;
        rise_en     = 8'h10;
        gpio_pin[4] = 1'b1;
        step(6);
        checks++; if (edge_status !== 8'h10) begin errors++; $display("FAIL mask_status: got %h want 10", edge_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", irq); end
        irq_mask = 8'hFF;
        step(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b want 1", irq); end
        checks++; if (edge_status !== 8'h10) begin errors++; $display("FAIL mask_status_kept: got %h want 10", edge_status); end
        dbnc_limit  = 8'd20;
        rise_en     = 8'h20;
        gpio_pin[5] = 1'b1;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gpio_value !== 8'h00) begin errors++; $display("FAIL midrst_value: got %h want 00", gpio_value); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL midrst_status: got %h want 00", edge_status); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
        // Pins 2, 4, 5 stay high through reset: seen as rises after release.
        dbnc_limit = 8'd1;
        rise_en    = 8'h24;
        step(1);
        rst_n = 1'b1;                // first sampling edge is k
        step(3);                     // after k+2
        checks++; if (gpio_value !== 8'h34) begin errors++; $display("FAIL release_value: got %h want 34", gpio_value); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL release_status_early: got %h want 00", edge_status); end
        step(1);
        checks++; if (edge_status !== 8'h24) begin errors++; $display("FAIL release_capture: got %h want 24", edge_status); end
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL release_clr: got %h want 00", edge_status); end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_fall_only();
        test_collision();
        test_mask_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gpio_in_capture
